// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: control, core handshake and result readback signals of
// the batch run controller. The controller uses the slave modport; whatever
// drives Go/Abort/CoreAck/RdIdx uses the master modport.
interface prog_sequencer_if #(
   parameter int NUM_PROGS = 3,
   parameter int CNT_W     = 16
);
   localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

   logic             Go;
   logic             Abort;
   logic             CoreAck;
   logic             CoreReset;
   logic             CoreStart;
   logic [PW-1:0]    ProgIdx;
   logic             Busy;
   logic             Done;
   logic             Error;
   logic [PW-1:0]    RdIdx;
   logic [CNT_W-1:0] RdCycles;

   modport master (
      output Go, Abort, CoreAck, RdIdx,
      input  CoreReset, CoreStart, ProgIdx, Busy, Done, Error, RdCycles
   );

   modport slave (
      input  Go, Abort, CoreAck, RdIdx,
      output CoreReset, CoreStart, ProgIdx, Busy, Done, Error, RdCycles
   );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: batch run controller for the 9-bit processor core.
// Holds the core in reset, then starts NUM_PROGS programs in order, timing
// each one in RUN cycles until the core acknowledges.
// Optional watchdog: define PROG_SEQ_TIMEOUT_EN to compile in the ERR state.
module prog_sequencer #(
   parameter int          NUM_PROGS = 3,
   parameter int          CNT_W     = 16,
   parameter int unsigned TIMEOUT   = 16'hFFFF
) (
   input logic             Clk,
   input logic             Reset,
   prog_sequencer_if.slave bus
);
   localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
   localparam logic [PW-1:0]    LAST_IDX = PW'(NUM_PROGS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef PROG_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CRST, S_START, S_RUN, S_NEXT, S_DONE
`ifdef PROG_SEQ_TIMEOUT_EN
      , S_ERR
`endif
   } state_t;

   state_t           state_q, state_d;
   logic             ph_q, ph_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    prog_idx_q, prog_idx_d;
   logic             core_reset_q, core_reset_d;
   logic             core_start_q, core_start_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] res_q [NUM_PROGS];
   logic [CNT_W-1:0] res_d [NUM_PROGS];
`ifdef PROG_SEQ_TIMEOUT_EN
   logic             error_q, error_d;
`endif

   // State register plus all registered outputs and result storage
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= S_IDLE;
         ph_q         <= 1'b0;
         cnt_q        <= '0;
         prog_idx_q   <= '0;
         core_reset_q <= 1'b1;
         core_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         res_q        <= '{default: '0};
`ifdef PROG_SEQ_TIMEOUT_EN
         error_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         cnt_q        <= cnt_d;
         prog_idx_q   <= prog_idx_d;
         core_reset_q <= core_reset_d;
         core_start_q <= core_start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         res_q        <= res_d;
`ifdef PROG_SEQ_TIMEOUT_EN
         error_q      <= error_d;
`endif
      end
   end

   // Next-state, program index, cycle counter and result capture
   always_comb begin
      state_d    = state_q;
      ph_d       = 1'b0;
      cnt_d      = cnt_q;
      prog_idx_d = prog_idx_q;
      res_d      = res_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.Go) begin
               state_d    = S_CRST;
               prog_idx_d = '0;
            end
         end
`ifdef PROG_SEQ_TIMEOUT_EN
         S_ERR: begin
            if (bus.Go) begin
               state_d    = S_CRST;
               prog_idx_d = '0;
            end
         end
`endif
         // ph_q marks the second cycle of the two-cycle CRST/START phases
         S_CRST: begin
            ph_d = ~ph_q;
            if (ph_q) state_d = S_START;
         end
         S_START: begin
            ph_d  = ~ph_q;
            cnt_d = '0;
            if (ph_q) state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.CoreAck) begin
               res_d[prog_idx_q] = cnt_q;
               state_d           = S_NEXT;
            end
`ifdef PROG_SEQ_TIMEOUT_EN
            else if (cnt_q == TO_LIM) begin
               res_d[prog_idx_q] = TO_LIM;
               state_d           = S_ERR;
            end
`endif
            else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_NEXT: begin
            if (prog_idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               prog_idx_d = prog_idx_q + PW'(1);
               state_d    = S_START;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Abort overrides everything, including a Go or Ack seen this cycle
      if (bus.Abort) begin
         state_d    = S_IDLE;
         ph_d       = 1'b0;
         prog_idx_d = prog_idx_q;
         res_d      = res_q;
      end
   end

   // Registered outputs are decoded from the upcoming state
   always_comb begin
      core_reset_d = (state_d == S_CRST);
      core_start_d = (state_d == S_START);
      busy_d       = (state_d inside {S_CRST, S_START, S_RUN, S_NEXT});
      done_d       = (state_d == S_DONE);
`ifdef PROG_SEQ_TIMEOUT_EN
      error_d = error_q;
      if (state_d == S_CRST && state_q != S_CRST) error_d = 1'b0;
      if (state_d == S_ERR) error_d = 1'b1;
`endif
   end

   assign bus.CoreReset = core_reset_q;
   assign bus.CoreStart = core_start_q;
   assign bus.ProgIdx   = prog_idx_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
`ifdef PROG_SEQ_TIMEOUT_EN
   assign bus.Error     = error_q;
`else
   assign bus.Error     = 1'b0;
`endif
   assign bus.RdCycles  = (int'(bus.RdIdx) < NUM_PROGS) ? res_q[bus.RdIdx] : '0;
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: drives batches through prog_sequencer with a simple
// core model (Ack after a chosen number of RUN cycles) and checks timing,
// status outputs and stored cycle counts against an array of expected results.
module tb_prog_sequencer;
   localparam int NP = 3;
   localparam int CW = 16;
   localparam int TO = 20;
   localparam int PW = $clog2(NP);

   logic Clk = 1'b0;
   logic Reset;

   prog_sequencer_if #(.NUM_PROGS(NP), .CNT_W(CW)) bus ();

   prog_sequencer #(.NUM_PROGS(NP), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_res [NP];
   int dly [NP];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_readback();
      for (int i = 0; i < NP; i++) begin
         bus.RdIdx = PW'(i);
         #1;
         n_cmp++;
         if (bus.RdCycles !== CW'(exp_res[i])) begin
            n_bad++;
            $display("FAIL result[%0d]: got %0d exp %0d", i, bus.RdCycles, exp_res[i]);
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      #2 Reset = 1'b0;
      #10;
      n_cmp++; if (bus.CoreReset !== 1'b1) begin n_bad++; $display("FAIL rst_corereset: got %b exp 1", bus.CoreReset); end
      n_cmp++; if (bus.CoreStart !== 1'b0) begin n_bad++; $display("FAIL rst_corestart: got %b exp 0", bus.CoreStart); end
      n_cmp++; if (bus.ProgIdx !== '0) begin n_bad++; $display("FAIL rst_progidx: got %0d exp 0", bus.ProgIdx); end
      n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b exp 0", bus.Busy); end
      n_cmp++; if (bus.Done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b exp 0", bus.Done); end
      n_cmp++; if (bus.Error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b exp 0", bus.Error); end
      for (int i = 0; i < NP; i++) exp_res[i] = 0;
      test_readback();
      @(negedge Clk) Reset = 1'b1;
      tick();
      n_cmp++; if (bus.CoreReset !== 1'b0) begin n_bad++; $display("FAIL rst_release_corereset: got %b exp 0", bus.CoreReset); end
      n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL rst_release_busy: got %b exp 0", bus.Busy); end
   endtask

   // One full batch using delays in dly[]; stale keeps Ack high until RUN,
   // go_prog injects a Go during that program's RUN phase (-1 = none).
   task automatic do_batch(input bit stale, input int go_prog);
      int n;
      bus.CoreAck = stale;
      bus.Go = 1'b1;
      tick();
      bus.Go = 1'b0;
      n_cmp++; if (bus.CoreReset !== 1'b1 || bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.CoreStart !== 1'b0)
         begin n_bad++; $display("FAIL crst1: got rst=%b busy=%b done=%b start=%b exp 1 1 0 0", bus.CoreReset, bus.Busy, bus.Done, bus.CoreStart); end
      n_cmp++; if (bus.Error !== 1'b0) begin n_bad++; $display("FAIL go_clr_error: got %b exp 0", bus.Error); end
      tick();
      n_cmp++; if (bus.CoreReset !== 1'b1 || bus.CoreStart !== 1'b0)
         begin n_bad++; $display("FAIL crst2: got rst=%b start=%b exp 1 0", bus.CoreReset, bus.CoreStart); end
      for (int p = 0; p < NP; p++) begin
         tick();
         n_cmp++; if (bus.CoreStart !== 1'b1 || bus.CoreReset !== 1'b0 || bus.ProgIdx !== PW'(p))
            begin n_bad++; $display("FAIL start1[%0d]: got start=%b rst=%b idx=%0d exp 1 0 %0d", p, bus.CoreStart, bus.CoreReset, bus.ProgIdx, p); end
         if (!stale) bus.CoreAck = 1'b0;
         tick();
         n_cmp++; if (bus.CoreStart !== 1'b1 || bus.Busy !== 1'b1)
            begin n_bad++; $display("FAIL start2[%0d]: got start=%b busy=%b exp 1 1", p, bus.CoreStart, bus.Busy); end
         tick();
         n_cmp++; if (bus.CoreStart !== 1'b0 || bus.Busy !== 1'b1)
            begin n_bad++; $display("FAIL run_entry[%0d]: got start=%b busy=%b exp 0 1", p, bus.CoreStart, bus.Busy); end
         bus.CoreAck = 1'b0;
         n = dly[p];
`ifdef PROG_SEQ_TIMEOUT_EN
         if (n >= TO) n = TO - 1;
`endif
         for (int i = 0; i < n; i++) begin
            if (p == go_prog && i == 0) bus.Go = 1'b1;
            tick();
            bus.Go = 1'b0;
         end
         bus.CoreAck = 1'b1;
         tick();
         exp_res[p] = n;
         n_cmp++; if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.CoreStart !== 1'b0)
            begin n_bad++; $display("FAIL next[%0d]: got busy=%b done=%b start=%b exp 1 0 0", p, bus.Busy, bus.Done, bus.CoreStart); end
      end
      tick();
      n_cmp++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || bus.CoreStart !== 1'b0 || bus.Error !== 1'b0)
         begin n_bad++; $display("FAIL done: got done=%b busy=%b start=%b err=%b exp 1 0 0 0", bus.Done, bus.Busy, bus.CoreStart, bus.Error); end
      bus.CoreAck = 1'b0;
   endtask

   task automatic test_batch();
      dly[0] = 10; dly[1] = 0; dly[2] = 37;
      do_batch(1'b0, -1);
   endtask

   task automatic test_stale_ack();
      for (int i = 0; i < NP; i++) dly[i] = $urandom_range(0, 30);
      do_batch(1'b1, -1);
   endtask

   task automatic test_random_batches();
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < NP; i++) dly[i] = $urandom_range(0, 40);
         do_batch(1'($urandom_range(0, 1)), -1);
         test_readback();
      end
   endtask

   task automatic test_abort();
      bus.CoreAck = 1'b0;
      bus.Go = 1'b1; tick(); bus.Go = 1'b0;
      repeat (4) tick();
      repeat (5) tick();
      bus.CoreAck = 1'b1; tick(); bus.CoreAck = 1'b0;
      exp_res[0] = 5;
      repeat (3) tick();
      n_cmp++; if (bus.ProgIdx !== PW'(1) || bus.Busy !== 1'b1)
         begin n_bad++; $display("FAIL abort_pre: got idx=%0d busy=%b exp 1 1", bus.ProgIdx, bus.Busy); end
      repeat (3) tick();
      bus.Abort = 1'b1; tick(); bus.Abort = 1'b0;
      n_cmp++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.CoreStart !== 1'b0 || bus.CoreReset !== 1'b0)
         begin n_bad++; $display("FAIL abort: got busy=%b done=%b start=%b rst=%b exp 0 0 0 0", bus.Busy, bus.Done, bus.CoreStart, bus.CoreReset); end
      repeat (3) tick();
      n_cmp++; if (bus.Busy !== 1'b0 || bus.CoreReset !== 1'b0)
         begin n_bad++; $display("FAIL abort_idle: got busy=%b rst=%b exp 0 0", bus.Busy, bus.CoreReset); end
   endtask

   task automatic test_go_abort_same();
      bus.Go = 1'b1; bus.Abort = 1'b1; tick(); bus.Go = 1'b0; bus.Abort = 1'b0;
      n_cmp++; if (bus.CoreReset !== 1'b0 || bus.Busy !== 1'b0)
         begin n_bad++; $display("FAIL go_abort: got rst=%b busy=%b exp 0 0", bus.CoreReset, bus.Busy); end
      tick();
      n_cmp++; if (bus.CoreStart !== 1'b0 || bus.Busy !== 1'b0)
         begin n_bad++; $display("FAIL go_abort_idle: got start=%b busy=%b exp 0 0", bus.CoreStart, bus.Busy); end
   endtask

   task automatic test_go_during_run();
      dly[0] = $urandom_range(0, 15); dly[1] = $urandom_range(3, 15); dly[2] = $urandom_range(0, 15);
      do_batch(1'b0, 1);
   endtask

`ifdef PROG_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      bus.CoreAck = 1'b0;
      bus.Go = 1'b1; tick(); bus.Go = 1'b0;
      repeat (4) tick();
      repeat (TO) tick();
      n_cmp++; if (bus.Busy !== 1'b1 || bus.Error !== 1'b0)
         begin n_bad++; $display("FAIL to_pre: got busy=%b err=%b exp 1 0", bus.Busy, bus.Error); end
      tick();
      exp_res[0] = TO;
      n_cmp++; if (bus.Error !== 1'b1 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.CoreStart !== 1'b0)
         begin n_bad++; $display("FAIL to_err: got err=%b busy=%b done=%b start=%b exp 1 0 0 0", bus.Error, bus.Busy, bus.Done, bus.CoreStart); end
      bus.Abort = 1'b1; tick(); bus.Abort = 1'b0;
      n_cmp++; if (bus.Error !== 1'b1 || bus.Busy !== 1'b0)
         begin n_bad++; $display("FAIL to_abort: got err=%b busy=%b exp 1 0", bus.Error, bus.Busy); end
      bus.Go = 1'b1; tick(); bus.Go = 1'b0;
      n_cmp++; if (bus.Error !== 1'b0 || bus.CoreReset !== 1'b1)
         begin n_bad++; $display("FAIL to_go: got err=%b rst=%b exp 0 1", bus.Error, bus.CoreReset); end
      bus.Abort = 1'b1; tick(); bus.Abort = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_run();
      bus.CoreAck = 1'b0;
      bus.Go = 1'b1; tick(); bus.Go = 1'b0;
      repeat (7) tick();
      #2 Reset = 1'b0;
      #1;
      n_cmp++; if (bus.CoreReset !== 1'b1 || bus.CoreStart !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Error !== 1'b0 || bus.ProgIdx !== '0)
         begin n_bad++; $display("FAIL mid_reset: got rst=%b start=%b busy=%b done=%b err=%b idx=%0d exp 1 0 0 0 0 0", bus.CoreReset, bus.CoreStart, bus.Busy, bus.Done, bus.Error, bus.ProgIdx); end
      for (int i = 0; i < NP; i++) begin
         bus.RdIdx = PW'(i);
         #1;
         n_cmp++; if (bus.RdCycles !== '0) begin n_bad++; $display("FAIL mid_reset_res[%0d]: got %0d exp 0", i, bus.RdCycles); end
         exp_res[i] = 0;
      end
      @(negedge Clk) Reset = 1'b1;
      tick();
      n_cmp++; if (bus.CoreReset !== 1'b0 || bus.Busy !== 1'b0)
         begin n_bad++; $display("FAIL mid_reset_release: got rst=%b busy=%b exp 0 0", bus.CoreReset, bus.Busy); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bus.Go = 1'b0; bus.Abort = 1'b0; bus.CoreAck = 1'b0; bus.RdIdx = '0;
      test_reset();
      test_batch();
      test_readback();
      test_stale_ack();
      test_readback();
      test_abort();
      test_readback();
      test_random_batches();
      test_go_abort_same();
      test_go_during_run();
      test_readback();
`ifdef PROG_SEQ_TIMEOUT_EN
      test_timeout();
      test_readback();
`endif
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
